stopwatch_core: RTL and testbench

//   Stopwatch time base downstream of the 1 kHz tick generator. Consumes the

---
 rtl/stopwatch_pkg.sv | 24 ++
 rtl/stopwatch_mod_counter.sv | 40 ++++
 rtl/stopwatch_core.sv | 136 +++++++++++++
 tb/tb_stopwatch_core.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared state encoding, cascade moduli and field widths for the stopwatch time base.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } sw_state_t;

  localparam int CSEC_MOD = 100;
  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;

  localparam int CSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  // A modulus of 1 still needs a one-bit register.
  function automatic int cnt_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/stopwatch_mod_counter.sv
// Modulo-MOD counter stage; carry fires when enabled at the terminal value.
module mod_counter
  import stopwatch_pkg::*;
#(
  parameter int MOD = 10,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_value,
  output logic [W-1:0] o_next,
  output logic         o_carry
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] r_value;

  // o_next exposes the post-edge value so a snapshot can include this cycle's increment.
  always_comb begin
    o_next = r_value;
    if (i_clr)
      o_next = '0;
    else if (i_en)
      o_next = (r_value == LAST) ? '0 : r_value + W'(1);
  end

  assign o_carry = i_en & (r_value == LAST);
  assign o_value = r_value;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_value <= '0;
    else if (i_clr | i_en)
      r_value <= o_next;
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch time base: tick prescaler, hh:mm:ss.cc cascade, run/stop/clear FSM and lap freeze.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_CSEC = 10,
  parameter int HOUR_MOD       = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_tick,
  input  logic              i_run_stop,
  input  logic              i_clear,
  input  logic              i_lap,
  output logic [CSEC_W-1:0] o_csec,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic              o_running,
  output logic              o_lap_active,
  output logic              o_wrap
);

  localparam int PRE_W = cnt_width(TICKS_PER_CSEC);

  sw_state_t         r_state;
  logic              r_running;
  logic              r_lap_active;
  logic              r_wrap;
  logic [CSEC_W-1:0] r_snap_csec;
  logic [SEC_W-1:0]  r_snap_sec;
  logic [MIN_W-1:0]  r_snap_min;
  logic [HOUR_W-1:0] r_snap_hour;

  logic              w_cnt_en;
  logic              w_clr;
  logic              w_pre_carry, w_csec_carry, w_sec_carry, w_min_carry, w_hour_carry;
  logic [PRE_W-1:0]  w_pre_val, w_pre_next;
  logic [CSEC_W-1:0] w_csec_val, w_csec_next;
  logic [SEC_W-1:0]  w_sec_val, w_sec_next;
  logic [MIN_W-1:0]  w_min_val, w_min_next;
  logic [HOUR_W-1:0] w_hour_val, w_hour_next;
  logic              w_unused;

  // Counting follows the current state, so a tick on the edge leaving RUN still counts.
  assign w_cnt_en = (r_state == ST_RUN) & i_tick;
  assign w_clr    = i_clear & (r_state != ST_RUN);
  assign w_unused = ^{w_pre_val, w_pre_next};

  mod_counter #(.MOD(TICKS_PER_CSEC), .W(PRE_W)) u_pre (
    .clk(clk), .reset(reset), .i_clr(w_clr), .i_en(w_cnt_en),
    .o_value(w_pre_val), .o_next(w_pre_next), .o_carry(w_pre_carry));

  mod_counter #(.MOD(CSEC_MOD), .W(CSEC_W)) u_csec (
    .clk(clk), .reset(reset), .i_clr(w_clr), .i_en(w_pre_carry),
    .o_value(w_csec_val), .o_next(w_csec_next), .o_carry(w_csec_carry));

  mod_counter #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
    .clk(clk), .reset(reset), .i_clr(w_clr), .i_en(w_csec_carry),
    .o_value(w_sec_val), .o_next(w_sec_next), .o_carry(w_sec_carry));

  mod_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
    .clk(clk), .reset(reset), .i_clr(w_clr), .i_en(w_sec_carry),
    .o_value(w_min_val), .o_next(w_min_next), .o_carry(w_min_carry));

  mod_counter #(.MOD(HOUR_MOD), .W(HOUR_W)) u_hour (
    .clk(clk), .reset(reset), .i_clr(w_clr), .i_en(w_min_carry),
    .o_value(w_hour_val), .o_next(w_hour_next), .o_carry(w_hour_carry));

  // Priority within a cycle: clear, then run_stop, then lap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_running    <= 1'b0;
      r_lap_active <= 1'b0;
      r_wrap       <= 1'b0;
      r_snap_csec  <= '0;
      r_snap_sec   <= '0;
      r_snap_min   <= '0;
      r_snap_hour  <= '0;
    end else begin
      r_wrap <= w_hour_carry;
      case (r_state)
        ST_IDLE: begin
          if (i_clear) begin
            r_lap_active <= 1'b0;
          end else if (i_run_stop) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end else if (i_lap) begin
            r_lap_active <= 1'b0;
          end
        end
        ST_RUN: begin
          if (i_run_stop) begin
            r_state   <= ST_STOP;
            r_running <= 1'b0;
          end else if (i_lap) begin
            if (!r_lap_active) begin
              r_snap_csec  <= w_csec_next;
              r_snap_sec   <= w_sec_next;
              r_snap_min   <= w_min_next;
              r_snap_hour  <= w_hour_next;
              r_lap_active <= 1'b1;
            end else begin
              r_lap_active <= 1'b0;
            end
          end
        end
        ST_STOP: begin
          if (i_clear) begin
            r_state      <= ST_IDLE;
            r_lap_active <= 1'b0;
          end else if (i_run_stop) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end else if (i_lap) begin
            r_lap_active <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign o_csec       = r_lap_active ? r_snap_csec : w_csec_val;
  assign o_sec        = r_lap_active ? r_snap_sec  : w_sec_val;
  assign o_min        = r_lap_active ? r_snap_min  : w_min_val;
  assign o_hour       = r_lap_active ? r_snap_hour : w_hour_val;
  assign o_running    = r_running;
  assign o_lap_active = r_lap_active;
  assign o_wrap       = r_wrap;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: directed scenarios plus random pulses against a total-tick reference model.
module tb_stopwatch_core;

  localparam int     TPC    = 10;
  localparam int     HMOD   = 24;
  localparam longint PERIOD = longint'(TPC) * 100 * 60 * 60 * HMOD;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0, rs = 1'b0, clr = 1'b0, lap = 1'b0;
  logic [6:0] s_csec;
  logic [5:0] s_sec, s_min;
  logic [4:0] s_hour;
  logic       s_run, s_lap, s_wrap;

  logic       wtick = 1'b0, wrs = 1'b0, wclr = 1'b0, wlap = 1'b0;
  logic [6:0] w_csec;
  logic [5:0] w_sec, w_min;
  logic [4:0] w_hour;
  logic       w_run, w_lapa, w_wrap;

  int errors = 0;
  int checks = 0;

  int     m_state;
  longint m_total, m_snap;
  bit     m_lap, m_wrap;

  stopwatch_core #(.TICKS_PER_CSEC(TPC), .HOUR_MOD(HMOD)) dut (
    .clk(clk), .reset(reset), .i_tick(tick), .i_run_stop(rs), .i_clear(clr), .i_lap(lap),
    .o_csec(s_csec), .o_sec(s_sec), .o_min(s_min), .o_hour(s_hour),
    .o_running(s_run), .o_lap_active(s_lap), .o_wrap(s_wrap));

  stopwatch_core #(.TICKS_PER_CSEC(1), .HOUR_MOD(24)) dut_w (
    .clk(clk), .reset(reset), .i_tick(wtick), .i_run_stop(wrs), .i_clear(wclr), .i_lap(wlap),
    .o_csec(w_csec), .o_sec(w_sec), .o_min(w_min), .o_hour(w_hour),
    .o_running(w_run), .o_lap_active(w_lapa), .o_wrap(w_wrap));

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_total = 0; m_snap = 0; m_lap = 0; m_wrap = 0;
  endtask

  // Elapsed time is one tick total; fields are derived by division.
  task automatic model_step(input bit t, input bit r, input bit c, input bit l);
    longint nt;
    nt = m_total;
    m_wrap = 0;
    if (m_state == 1 && t) begin
      nt = m_total + 1;
      if (nt == PERIOD) begin nt = 0; m_wrap = 1; end
    end
    case (m_state)
      0: if (c) begin nt = 0; m_lap = 0; end
         else if (r) m_state = 1;
         else if (l) m_lap = 0;
      1: if (r) m_state = 2;
         else if (l) begin
           if (!m_lap) begin m_snap = nt; m_lap = 1; end
           else m_lap = 0;
         end
      default: if (c) begin m_state = 0; nt = 0; m_lap = 0; end
               else if (r) m_state = 1;
               else if (l) m_lap = 0;
    endcase
    m_total = nt;
  endtask

  function automatic logic [26:0] exp_vec();
    longint cs;
    logic [26:0] v;
    cs = (m_lap ? m_snap : m_total) / TPC;
    v[26:20] = 7'(cs % 100);
    v[19:14] = 6'((cs / 100) % 60);
    v[13:8]  = 6'((cs / 6000) % 60);
    v[7:3]   = 5'((cs / 360000) % HMOD);
    v[2]     = (m_state == 1);
    v[1]     = m_lap;
    v[0]     = m_wrap;
    return v;
  endfunction

  task automatic drive(input bit t, input bit r, input bit c, input bit l);
    @(negedge clk);
    tick = t; rs = r; clr = c; lap = l;
    model_step(t, r, c, l);
    @(posedge clk);
    #1;
    tick = 0; rs = 0; clr = 0; lap = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0);
  endtask

  task automatic wdrive(input bit t, input bit r);
    @(negedge clk);
    wtick = t; wrs = r;
    @(posedge clk);
    #1;
    wtick = 0; wrs = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    model_reset();
    #2;
    reset = 0;
  endtask

  task automatic test_reset();
    #1 reset = 1;
    model_reset();
    #1;
    checks++;
    if ({s_csec, s_sec, s_min, s_hour, s_run, s_lap, s_wrap} !== 27'd0)
      begin errors++; $display("FAIL reset_async got %0d:%0d:%0d.%0d run=%0b lap=%0b wrap=%0b want all 0",
        s_hour, s_min, s_sec, s_csec, s_run, s_lap, s_wrap); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({w_csec, w_sec, w_min, w_hour, w_run, w_lapa, w_wrap} !== 27'd0)
      begin errors++; $display("FAIL reset_held_w got %0d:%0d:%0d.%0d run=%0b want all 0",
        w_hour, w_min, w_sec, w_csec, w_run); end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_run_second();
    do_reset();
    drive(0, 1, 0, 0);
    ticks(1000);
    checks++;
    if ({s_hour, s_min, s_sec, s_csec, s_run} !== {5'd0, 6'd0, 6'd1, 7'd0, 1'b1})
      begin errors++; $display("FAIL run_1s got %0d:%0d:%0d.%0d run=%0b want 0:0:1.0 run=1",
        s_hour, s_min, s_sec, s_csec, s_run); end
  endtask

  task automatic test_stop_clear();
    do_reset();
    drive(0, 1, 0, 0);
    ticks(1234);
    drive(0, 1, 0, 0);
    ticks(50);
    checks++;
    if ({s_hour, s_min, s_sec, s_csec, s_run} !== {5'd0, 6'd0, 6'd1, 7'd23, 1'b0})
      begin errors++; $display("FAIL stop_hold got %0d:%0d:%0d.%0d run=%0b want 0:0:1.23 run=0",
        s_hour, s_min, s_sec, s_csec, s_run); end
    drive(0, 0, 1, 0);
    checks++;
    if ({s_csec, s_sec, s_min, s_hour, s_run, s_lap} !== 26'd0)
      begin errors++; $display("FAIL clear_stop got %0d:%0d:%0d.%0d run=%0b want all 0",
        s_hour, s_min, s_sec, s_csec, s_run); end
    drive(0, 1, 0, 0);
    ticks(25);
    drive(0, 0, 1, 0);
    checks++;
    if ({s_csec, s_run} !== {7'd2, 1'b1})
      begin errors++; $display("FAIL clear_in_run got csec=%0d run=%0b want csec=2 run=1", s_csec, s_run); end
    drive(0, 1, 0, 0);
    drive(0, 1, 1, 0);
    checks++;
    if ({s_csec, s_run} !== {7'd0, 1'b0})
      begin errors++; $display("FAIL clear_over_runstop got csec=%0d run=%0b want csec=0 run=0", s_csec, s_run); end
  endtask

  task automatic test_wrap();
    do_reset();
    wdrive(0, 1);
    wdrive(0, 1);
    @(negedge clk);
    force dut_w.u_sec.r_value  = 6'd59;
    force dut_w.u_min.r_value  = 6'd59;
    force dut_w.u_hour.r_value = 5'd23;
    @(posedge clk);
    #1;
    release dut_w.u_sec.r_value;
    release dut_w.u_min.r_value;
    release dut_w.u_hour.r_value;
    wdrive(0, 1);
    for (int i = 0; i < 99; i++) wdrive(1, 0);
    checks++;
    if ({w_hour, w_min, w_sec, w_csec, w_wrap} !== {5'd23, 6'd59, 6'd59, 7'd99, 1'b0})
      begin errors++; $display("FAIL wrap_preload got %0d:%0d:%0d.%0d wrap=%0b want 23:59:59.99 wrap=0",
        w_hour, w_min, w_sec, w_csec, w_wrap); end
    wdrive(1, 0);
    checks++;
    if ({w_hour, w_min, w_sec, w_csec, w_wrap, w_run} !== {5'd0, 6'd0, 6'd0, 7'd0, 1'b1, 1'b1})
      begin errors++; $display("FAIL wrap_roll got %0d:%0d:%0d.%0d wrap=%0b run=%0b want 0:0:0.0 wrap=1 run=1",
        w_hour, w_min, w_sec, w_csec, w_wrap, w_run); end
    wdrive(0, 0);
    checks++;
    if (w_wrap !== 1'b0)
      begin errors++; $display("FAIL wrap_pulse got wrap=%0b want 0", w_wrap); end
    wdrive(1, 0);
    checks++;
    if ({w_csec, w_wrap} !== {7'd1, 1'b0})
      begin errors++; $display("FAIL wrap_continue got csec=%0d wrap=%0b want csec=1 wrap=0", w_csec, w_wrap); end
  endtask

  task automatic test_lap();
    do_reset();
    drive(0, 1, 0, 0);
    ticks(500);
    drive(0, 0, 0, 1);
    checks++;
    if ({s_sec, s_csec, s_lap} !== {6'd0, 7'd50, 1'b1})
      begin errors++; $display("FAIL lap_freeze got %0d.%0d lap=%0b want 0.50 lap=1", s_sec, s_csec, s_lap); end
    ticks(3000);
    checks++;
    if ({s_sec, s_csec, s_lap} !== {6'd0, 7'd50, 1'b1})
      begin errors++; $display("FAIL lap_hold got %0d.%0d lap=%0b want 0.50 lap=1", s_sec, s_csec, s_lap); end
    drive(0, 0, 0, 1);
    checks++;
    if ({s_sec, s_csec, s_lap} !== {6'd3, 7'd50, 1'b0})
      begin errors++; $display("FAIL lap_release got %0d.%0d lap=%0b want 3.50 lap=0", s_sec, s_csec, s_lap); end
  endtask

  task automatic test_coincident();
    do_reset();
    drive(1, 1, 0, 0);
    ticks(9);
    checks++;
    if ({s_csec, s_run} !== {7'd0, 1'b1})
      begin errors++; $display("FAIL tick_on_start got csec=%0d run=%0b want csec=0 run=1", s_csec, s_run); end
    ticks(1);
    checks++;
    if (s_csec !== 7'd1)
      begin errors++; $display("FAIL tick_10 got csec=%0d want 1", s_csec); end
    ticks(6);
    drive(1, 1, 0, 0);
    ticks(5);
    drive(0, 1, 0, 0);
    ticks(2);
    checks++;
    if ({s_csec, s_run} !== {7'd1, 1'b1})
      begin errors++; $display("FAIL resume_phase got csec=%0d run=%0b want csec=1 run=1", s_csec, s_run); end
    ticks(1);
    checks++;
    if (s_csec !== 7'd2)
      begin errors++; $display("FAIL tick_on_stop got csec=%0d want 2", s_csec); end
  endtask

  task automatic test_random();
    int shown;
    logic [26:0] got, want;
    shown = 0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3);
      got  = {s_csec, s_sec, s_min, s_hour, s_run, s_lap, s_wrap};
      want = exp_vec();
      checks++;
      if (got !== want) begin
        errors++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random cycle %0d got %h want %h", i, got, want);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(0, 1, 0, 0);
    ticks(700);
    drive(0, 0, 0, 1);
    ticks(20);
    checks++;
    if ({s_csec, s_lap} !== {7'd70, 1'b1})
      begin errors++; $display("FAIL pre_reset_lap got csec=%0d lap=%0b want csec=70 lap=1", s_csec, s_lap); end
    #2 reset = 1;
    model_reset();
    #1;
    checks++;
    if ({s_csec, s_sec, s_min, s_hour, s_run, s_lap, s_wrap} !== 27'd0)
      begin errors++; $display("FAIL reset_mid got %0d:%0d:%0d.%0d run=%0b lap=%0b want all 0",
        s_hour, s_min, s_sec, s_csec, s_run, s_lap); end
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_run_second();
    test_stop_clear();
    test_wrap();
    test_lap();
    test_coincident();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
